// File: rtl/riscv_core_axi_pkg.sv
// riscv_core_axi_pkg: shared AXI4 encodings and the refill FSM state type.
//   AXI_BURST_INCR         ARBURST encoding for incrementing bursts
//   AXI_RESP_*             RRESP encodings
//   refill_state_e         IDLE -> ADDR -> DATA -> DONE refill sequence
package riscv_core_axi_pkg;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } refill_state_e;
endpackage

// File: rtl/riscv_core_icache_axi_refill.sv
// riscv_core_icache_axi_refill: turns one I-cache refill request into a single AXI4 INCR read burst
// and assembles the beats into one cache line, pulsing o_mem_done once the line is complete.
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_mem_req, i_addr           refill request (level) and address from the cache controller
//   o_mem_done, o_line, o_err   one-cycle completion pulse, assembled line, sticky burst error
//   o_ar*, i_arready            AXI read-address channel (single burst, constant id)
//   i_r*, o_rready              AXI read-data channel
module riscv_core_icache_axi_refill
    import riscv_core_axi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int LINE_WIDTH     = 256,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ID         = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_mem_req,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    output logic                      o_mem_done,
    output logic [LINE_WIDTH-1:0]     o_line,
    output logic                      o_err,
    output logic [AXI_ID_WIDTH-1:0]   o_arid,
    output logic [ADDR_WIDTH-1:0]     o_araddr,
    output logic [7:0]                o_arlen,
    output logic [2:0]                o_arsize,
    output logic [1:0]                o_arburst,
    output logic                      o_arvalid,
    input  logic                      i_arready,
    input  logic [AXI_ID_WIDTH-1:0]   i_rid,
    input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]                i_rresp,
    input  logic                      i_rlast,
    input  logic                      i_rvalid,
    output logic                      o_rready
);
    localparam int BEATS      = LINE_WIDTH / AXI_DATA_WIDTH;
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ARSIZE_C   = $clog2(AXI_DATA_WIDTH / 8);
    localparam int LINE_BYTES = LINE_WIDTH / 8;

    refill_state_e           r_state;
    refill_state_e           w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic [LINE_WIDTH-1:0]   r_line;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_err;
    logic                    w_accept;
    logic                    w_beat;
    logic                    w_last_cnt;
    logic                    w_beat_err;

    assign w_accept   = (r_state == ST_IDLE) && i_mem_req;
    assign w_beat     = (r_state == ST_DATA) && i_rvalid;
    assign w_last_cnt = (r_cnt == CNT_W'(BEATS - 1));
    // rlast must coincide exactly with the counter's final beat; the counter alone ends the burst
    assign w_beat_err = (i_rresp == AXI_RESP_SLVERR) || (i_rresp == AXI_RESP_DECERR) ||
                        (i_rid != AXI_ID_WIDTH'(AXI_ID)) || (i_rlast != w_last_cnt);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: w_state_nxt = i_mem_req ? ST_ADDR : ST_IDLE;
            ST_ADDR: w_state_nxt = i_arready ? ST_DATA : ST_ADDR;
            ST_DATA: w_state_nxt = (i_rvalid && w_last_cnt) ? ST_DONE : ST_DATA;
            ST_DONE: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_arvalid  = (r_state == ST_ADDR);
        o_rready   = (r_state == ST_DATA);
        o_mem_done = (r_state == ST_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_araddr <= '0;
            r_line   <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_araddr <= i_addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else if (w_beat) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_err <= r_err | w_beat_err;
            for (int b = 0; b < BEATS; b++)
                if (r_cnt == CNT_W'(b)) r_line[b*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_rdata;
        end
    end

    assign o_araddr  = r_araddr;
    assign o_line    = r_line;
    assign o_err     = r_err;
    assign o_arid    = AXI_ID_WIDTH'(AXI_ID);
    assign o_arlen   = 8'(BEATS - 1);
    assign o_arsize  = 3'(ARSIZE_C);
    assign o_arburst = AXI_BURST_INCR;
endmodule
